// File: rtl/management_bus_arbiter_pkg.sv
// Shared types and constants for the management bus arbiter: FSM state
// encoding, requester IDs (which double as one-hot grant vectors) and the
// read value returned when the target times out.
package management_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  // Bit 0 is JTAG, bit 1 is WB, so an ID is also a one-hot grant vector.
  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_JTAG = 2'b01;
  localparam logic [1:0] REQ_WB   = 2'b10;

  localparam logic [31:0] TIMEOUT_READ_VALUE = 32'hFFFF_FFFF;

endpackage

// File: rtl/management_bus_arbiter_if.sv
// Bundle of requester and target signals around the management bus arbiter.
//
// Handshakes: each requester raises <x>_req with its command fields stable and
// holds them until it sees <x>_ack for one cycle; <x>_readData/<x>_error are
// valid in the ack cycle and held until the next ack to that requester. On the
// target side management_enable stays high, with the command stable, until
// the cycle in which management_ready is sampled high (or the wait times out).
interface management_bus_arbiter_if;
  import management_bus_arbiter_pkg::*;

  logic        jtag_req;
  logic        jtag_writeEnable;
  logic [3:0]  jtag_byteSelect;
  logic [19:0] jtag_address;
  logic [31:0] jtag_writeData;
  logic        jtag_ack;
  logic        jtag_error;
  logic [31:0] jtag_readData;

  logic        wb_req;
  logic        wb_writeEnable;
  logic [3:0]  wb_byteSelect;
  logic [19:0] wb_address;
  logic [31:0] wb_writeData;
  logic        wb_ack;
  logic        wb_error;
  logic [31:0] wb_readData;

  logic        management_enable;
  logic        management_writeEnable;
  logic [3:0]  management_byteSelect;
  logic [19:0] management_address;
  logic [31:0] management_writeData;
  logic [31:0] management_readData;
  logic        management_ready;

  logic [1:0]  active_requester;
  arb_state_t  arb_state;

  // Arbiter side.
  modport slave (
    input  jtag_req, jtag_writeEnable, jtag_byteSelect, jtag_address, jtag_writeData,
    output jtag_ack, jtag_error, jtag_readData,
    input  wb_req, wb_writeEnable, wb_byteSelect, wb_address, wb_writeData,
    output wb_ack, wb_error, wb_readData,
    output management_enable, management_writeEnable, management_byteSelect,
    output management_address, management_writeData,
    input  management_readData, management_ready,
    output active_requester, arb_state
  );

  // Requesters plus target side.
  modport master (
    output jtag_req, jtag_writeEnable, jtag_byteSelect, jtag_address, jtag_writeData,
    input  jtag_ack, jtag_error, jtag_readData,
    output wb_req, wb_writeEnable, wb_byteSelect, wb_address, wb_writeData,
    input  wb_ack, wb_error, wb_readData,
    input  management_enable, management_writeEnable, management_byteSelect,
    input  management_address, management_writeData,
    output management_readData, management_ready,
    input  active_requester, arb_state
  );

endinterface

// File: rtl/management_bus_arbiter_round_robin_arbiter2.sv
// Two-way arbiter: single requests pass straight through; on a tie the
// requester that did not win last time is chosen (round robin) or JTAG always
// wins (fixed priority). Purely combinational, one-hot output.
module round_robin_arbiter2
  import management_bus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic [1:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] grant
);

  // Resolve ties; otherwise the lone request is the grant.
  always_comb begin
    grant = req;
    if (req == (REQ_JTAG | REQ_WB)) begin
      if ((ROUND_ROBIN != 0) && (last_grant == REQ_JTAG)) begin
        grant = REQ_WB;
      end else begin
        grant = REQ_JTAG;
      end
    end
  end

endmodule

// File: rtl/management_bus_arbiter.sv
// Shares the core's management port between the JTAG debug controller and the
// WB management bridge. One access at a time: IDLE picks a winner and latches
// its command, ACCESS drives the target until ready or timeout, DONE pulses
// the winner's ack with its result already registered.
module management_bus_arbiter
  import management_bus_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                      clk,
  input logic                      rst,
  management_bus_arbiter_if.slave  bus
);

  // Counter sized to hold TIMEOUT_CYCLES; kept at least one bit wide.
  localparam int CW          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_INT);

  arb_state_t  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [1:0]  mask_q, mask_d;
  logic [CW-1:0] count_q, count_d;

  logic        mgmt_enable_q, mgmt_enable_d;
  logic        mgmt_we_q, mgmt_we_d;
  logic [3:0]  mgmt_be_q, mgmt_be_d;
  logic [19:0] mgmt_addr_q, mgmt_addr_d;
  logic [31:0] mgmt_wdata_q, mgmt_wdata_d;

  logic        jtag_ack_q, jtag_ack_d;
  logic        jtag_error_q, jtag_error_d;
  logic [31:0] jtag_rdata_q, jtag_rdata_d;
  logic        wb_ack_q, wb_ack_d;
  logic        wb_error_q, wb_error_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic [1:0]  active_q, active_d;

  logic [1:0]  req_masked;
  logic [1:0]  arb_grant;
  logic        timeout_hit;
  logic [31:0] result_data;
  logic        result_error;

  // A requester acked last cycle may still show req; ignore it for one cycle.
  assign req_masked  = {bus.wb_req, bus.jtag_req} & ~mask_q;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == TO_LAST);

  round_robin_arbiter2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .req        (req_masked),
    .last_grant (last_grant_q),
    .grant      (arb_grant)
  );

  // Next-state and next-output logic for the IDLE/ACCESS/DONE sequence.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    mask_d        = {wb_ack_q, jtag_ack_q};
    count_d       = count_q;
    mgmt_enable_d = mgmt_enable_q;
    mgmt_we_d     = mgmt_we_q;
    mgmt_be_d     = mgmt_be_q;
    mgmt_addr_d   = mgmt_addr_q;
    mgmt_wdata_d  = mgmt_wdata_q;
    jtag_ack_d    = 1'b0;
    jtag_error_d  = jtag_error_q;
    jtag_rdata_d  = jtag_rdata_q;
    wb_ack_d      = 1'b0;
    wb_error_d    = wb_error_q;
    wb_rdata_d    = wb_rdata_q;
    active_d      = active_q;
    result_data   = TIMEOUT_READ_VALUE;
    result_error  = 1'b1;

    case (state_q)
      ARB_IDLE: begin
        if (arb_grant != REQ_NONE) begin
          state_d       = ARB_ACCESS;
          grant_d       = arb_grant;
          active_d      = arb_grant;
          count_d       = '0;
          mgmt_enable_d = 1'b1;
          if (arb_grant == REQ_JTAG) begin
            mgmt_we_d    = bus.jtag_writeEnable;
            mgmt_be_d    = bus.jtag_byteSelect;
            mgmt_addr_d  = bus.jtag_address;
            mgmt_wdata_d = bus.jtag_writeEnable ? bus.jtag_writeData : 32'd0;
          end else begin
            mgmt_we_d    = bus.wb_writeEnable;
            mgmt_be_d    = bus.wb_byteSelect;
            mgmt_addr_d  = bus.wb_address;
            mgmt_wdata_d = bus.wb_writeEnable ? bus.wb_writeData : 32'd0;
          end
        end
      end

      ARB_ACCESS: begin
        if (bus.management_ready || timeout_hit) begin
          if (bus.management_ready) begin
            result_data  = mgmt_we_q ? 32'd0 : bus.management_readData;
            result_error = 1'b0;
          end
          state_d       = ARB_DONE;
          mgmt_enable_d = 1'b0;
          mgmt_we_d     = 1'b0;
          mgmt_be_d     = 4'd0;
          mgmt_addr_d   = 20'd0;
          mgmt_wdata_d  = 32'd0;
          if (grant_q == REQ_JTAG) begin
            jtag_ack_d   = 1'b1;
            jtag_rdata_d = result_data;
            jtag_error_d = result_error;
          end else begin
            wb_ack_d     = 1'b1;
            wb_rdata_d   = result_data;
            wb_error_d   = result_error;
          end
        end else if (count_q != {CW{1'b1}}) begin
          count_d = count_q + CW'(1);
        end
      end

      ARB_DONE: begin
        state_d      = ARB_IDLE;
        last_grant_d = grant_q;
        grant_d      = REQ_NONE;
        active_d     = REQ_NONE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= REQ_NONE;
      last_grant_q  <= REQ_WB;
      mask_q        <= 2'b00;
      count_q       <= '0;
      mgmt_enable_q <= 1'b0;
      mgmt_we_q     <= 1'b0;
      mgmt_be_q     <= 4'd0;
      mgmt_addr_q   <= 20'd0;
      mgmt_wdata_q  <= 32'd0;
      jtag_ack_q    <= 1'b0;
      jtag_error_q  <= 1'b0;
      jtag_rdata_q  <= 32'd0;
      wb_ack_q      <= 1'b0;
      wb_error_q    <= 1'b0;
      wb_rdata_q    <= 32'd0;
      active_q      <= REQ_NONE;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      mask_q        <= mask_d;
      count_q       <= count_d;
      mgmt_enable_q <= mgmt_enable_d;
      mgmt_we_q     <= mgmt_we_d;
      mgmt_be_q     <= mgmt_be_d;
      mgmt_addr_q   <= mgmt_addr_d;
      mgmt_wdata_q  <= mgmt_wdata_d;
      jtag_ack_q    <= jtag_ack_d;
      jtag_error_q  <= jtag_error_d;
      jtag_rdata_q  <= jtag_rdata_d;
      wb_ack_q      <= wb_ack_d;
      wb_error_q    <= wb_error_d;
      wb_rdata_q    <= wb_rdata_d;
      active_q      <= active_d;
    end
  end

  assign bus.jtag_ack               = jtag_ack_q;
  assign bus.jtag_error             = jtag_error_q;
  assign bus.jtag_readData          = jtag_rdata_q;
  assign bus.wb_ack                 = wb_ack_q;
  assign bus.wb_error               = wb_error_q;
  assign bus.wb_readData            = wb_rdata_q;
  assign bus.management_enable      = mgmt_enable_q;
  assign bus.management_writeEnable = mgmt_we_q;
  assign bus.management_byteSelect  = mgmt_be_q;
  assign bus.management_address     = mgmt_addr_q;
  assign bus.management_writeData   = mgmt_wdata_q;
  assign bus.active_requester       = active_q;
  assign bus.arb_state              = state_q;

endmodule

// File: tb/tb_management_bus_arbiter.sv
// Directed bench for management_bus_arbiter. Two instances share all inputs:
// dut_rr (round robin) and dut_fp (fixed priority), both with a 4-cycle timeout.
module tb_management_bus_arbiter;
  import management_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        jtag_req, jtag_we;
  logic [3:0]  jtag_be;
  logic [19:0] jtag_addr;
  logic [31:0] jtag_wdata;
  logic        wb_req, wb_we;
  logic [3:0]  wb_be;
  logic [19:0] wb_addr;
  logic [31:0] wb_wdata;
  logic        mgmt_ready;
  logic [31:0] mgmt_rdata;

  management_bus_arbiter_if if_rr ();
  management_bus_arbiter_if if_fp ();

  assign if_rr.jtag_req = jtag_req;           assign if_fp.jtag_req = jtag_req;
  assign if_rr.jtag_writeEnable = jtag_we;    assign if_fp.jtag_writeEnable = jtag_we;
  assign if_rr.jtag_byteSelect = jtag_be;     assign if_fp.jtag_byteSelect = jtag_be;
  assign if_rr.jtag_address = jtag_addr;      assign if_fp.jtag_address = jtag_addr;
  assign if_rr.jtag_writeData = jtag_wdata;   assign if_fp.jtag_writeData = jtag_wdata;
  assign if_rr.wb_req = wb_req;               assign if_fp.wb_req = wb_req;
  assign if_rr.wb_writeEnable = wb_we;        assign if_fp.wb_writeEnable = wb_we;
  assign if_rr.wb_byteSelect = wb_be;         assign if_fp.wb_byteSelect = wb_be;
  assign if_rr.wb_address = wb_addr;          assign if_fp.wb_address = wb_addr;
  assign if_rr.wb_writeData = wb_wdata;       assign if_fp.wb_writeData = wb_wdata;
  assign if_rr.management_ready = mgmt_ready; assign if_fp.management_ready = mgmt_ready;
  assign if_rr.management_readData = mgmt_rdata;
  assign if_fp.management_readData = mgmt_rdata;

  management_bus_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) dut_rr (
    .clk (clk), .rst (rst), .bus (if_rr.slave));
  management_bus_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(4)) dut_fp (
    .clk (clk), .rst (rst), .bus (if_fp.slave));

  // ---------------- clock/reset helpers and drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    jtag_req = 0; jtag_we = 0; jtag_be = 0; jtag_addr = 0; jtag_wdata = 0;
    wb_req = 0; wb_we = 0; wb_be = 0; wb_addr = 0; wb_wdata = 0;
    mgmt_ready = 0; mgmt_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (if_rr.arb_state !== ARB_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", if_rr.arb_state, ARB_IDLE); end
    checks++; if (if_rr.management_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", if_rr.management_enable); end
    checks++; if (if_rr.jtag_readData !== 32'd0) begin errors++; $display("FAIL reset_jtag_rdata: got %h want 0", if_rr.jtag_readData); end
    checks++; if (if_rr.wb_readData !== 32'd0) begin errors++; $display("FAIL reset_wb_rdata: got %h want 0", if_rr.wb_readData); end
    checks++; if ({if_rr.jtag_ack, if_rr.wb_ack, if_rr.jtag_error, if_rr.wb_error} !== 4'b0) begin errors++; $display("FAIL reset_ack_err: got %b want 0000", {if_rr.jtag_ack, if_rr.wb_ack, if_rr.jtag_error, if_rr.wb_error}); end
    checks++; if (if_rr.active_requester !== REQ_NONE) begin errors++; $display("FAIL reset_active: got %b want 00", if_rr.active_requester); end
  endtask

  task automatic test_jtag_read();
    jtag_req = 1; jtag_we = 0; jtag_be = 4'hF; jtag_addr = 20'h00010;
    mgmt_ready = 1; mgmt_rdata = 32'hDEADBEEF;
    tick();
    checks++; if (if_rr.management_enable !== 1'b1) begin errors++; $display("FAIL jr_enable: got %b want 1", if_rr.management_enable); end
    checks++; if (if_rr.management_address !== 20'h00010) begin errors++; $display("FAIL jr_addr: got %h want 00010", if_rr.management_address); end
    checks++; if (if_rr.active_requester !== REQ_JTAG) begin errors++; $display("FAIL jr_active: got %b want 01", if_rr.active_requester); end
    checks++; if (if_rr.management_writeData !== 32'd0) begin errors++; $display("FAIL jr_wdata: got %h want 0", if_rr.management_writeData); end
    tick();
    checks++; if (if_rr.jtag_ack !== 1'b1) begin errors++; $display("FAIL jr_ack: got %b want 1", if_rr.jtag_ack); end
    checks++; if (if_rr.management_enable !== 1'b0) begin errors++; $display("FAIL jr_enable_off: got %b want 0", if_rr.management_enable); end
    checks++; if (if_rr.jtag_readData !== 32'hDEADBEEF) begin errors++; $display("FAIL jr_rdata: got %h want deadbeef", if_rr.jtag_readData); end
    checks++; if (if_rr.jtag_error !== 1'b0) begin errors++; $display("FAIL jr_error: got %b want 0", if_rr.jtag_error); end
    checks++; if (if_rr.wb_ack !== 1'b0) begin errors++; $display("FAIL jr_wb_ack: got %b want 0", if_rr.wb_ack); end
    jtag_req = 0;
    tick();
    checks++; if (if_rr.jtag_ack !== 1'b0) begin errors++; $display("FAIL jr_ack_pulse: got %b want 0", if_rr.jtag_ack); end
    checks++; if (if_rr.jtag_readData !== 32'hDEADBEEF) begin errors++; $display("FAIL jr_rdata_hold: got %h want deadbeef", if_rr.jtag_readData); end
  endtask

  task automatic test_wb_write();
    mgmt_ready = 0; mgmt_rdata = 32'hCAFE0000;
    wb_req = 1; wb_we = 1; wb_be = 4'h3; wb_addr = 20'h00404; wb_wdata = 32'h12345678;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (if_rr.management_enable !== 1'b1) begin errors++; $display("FAIL ww_enable[%0d]: got %b want 1", i, if_rr.management_enable); end
      checks++; if (if_rr.management_writeData !== 32'h12345678) begin errors++; $display("FAIL ww_wdata[%0d]: got %h want 12345678", i, if_rr.management_writeData); end
      checks++; if (if_rr.management_byteSelect !== 4'h3) begin errors++; $display("FAIL ww_be[%0d]: got %h want 3", i, if_rr.management_byteSelect); end
      checks++; if ({if_rr.management_writeEnable, if_rr.management_address} !== {1'b1, 20'h00404}) begin errors++; $display("FAIL ww_cmd[%0d]: got %h want 100404", i, {if_rr.management_writeEnable, if_rr.management_address}); end
      checks++; if (if_rr.wb_ack !== 1'b0) begin errors++; $display("FAIL ww_early_ack[%0d]: got %b want 0", i, if_rr.wb_ack); end
      if (i == 2) mgmt_ready = 1;
      tick();
    end
    checks++; if (if_rr.wb_ack !== 1'b1) begin errors++; $display("FAIL ww_ack: got %b want 1", if_rr.wb_ack); end
    checks++; if (if_rr.wb_readData !== 32'd0) begin errors++; $display("FAIL ww_rdata: got %h want 0", if_rr.wb_readData); end
    checks++; if (if_rr.wb_error !== 1'b0) begin errors++; $display("FAIL ww_error: got %b want 0", if_rr.wb_error); end
    checks++; if (if_rr.jtag_readData !== 32'hDEADBEEF) begin errors++; $display("FAIL ww_jtag_untouched: got %h want deadbeef", if_rr.jtag_readData); end
    checks++; if (if_rr.jtag_ack !== 1'b0) begin errors++; $display("FAIL ww_jtag_ack: got %b want 0", if_rr.jtag_ack); end
    wb_req = 0; mgmt_ready = 0;
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_a[4];
    logic [1:0] exp_rr_b[3];
    logic [1:0] exp_fp_b[3];
    logic [1:0] rr_ord[4];
    logic [1:0] fp_ord[4];
    int nr, nf;
    bit seen;
    exp_a    = '{REQ_JTAG, REQ_WB, REQ_JTAG, REQ_WB};
    exp_rr_b = '{REQ_WB, REQ_JTAG, REQ_WB};
    exp_fp_b = '{REQ_JTAG, REQ_WB, REQ_JTAG};

    // Scenario A: fresh reset, both hold requests.
    do_reset();
    mgmt_ready = 1; mgmt_rdata = 32'h0000_00A5;
    jtag_req = 1; wb_req = 1;
    nr = 0; nf = 0;
    for (int c = 0; c < 60 && (nr < 4 || nf < 4); c++) begin
      tick();
      if (nr < 4 && (if_rr.jtag_ack || if_rr.wb_ack)) begin rr_ord[nr] = {if_rr.wb_ack, if_rr.jtag_ack}; nr++; end
      if (nf < 4 && (if_fp.jtag_ack || if_fp.wb_ack)) begin fp_ord[nf] = {if_fp.wb_ack, if_fp.jtag_ack}; nf++; end
    end
    checks++; if (nr != 4 || nf != 4) begin errors++; $display("FAIL cont_a_budget: got rr=%0d fp=%0d grants want 4", nr, nf); end
    for (int i = 0; i < 4; i++) begin
      if (i < nr) begin checks++; if (rr_ord[i] !== exp_a[i]) begin errors++; $display("FAIL cont_a_rr[%0d]: got %b want %b", i, rr_ord[i], exp_a[i]); end end
      if (i < nf) begin checks++; if (fp_ord[i] !== exp_a[i]) begin errors++; $display("FAIL cont_a_fp[%0d]: got %b want %b", i, fp_ord[i], exp_a[i]); end end
    end

    // Scenario B: JTAG wins alone, then both request after the mask clears.
    do_reset();
    mgmt_ready = 1;
    jtag_req = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (if_rr.jtag_ack) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL cont_b_solo: got no jtag_ack want ack"); end
    jtag_req = 0;
    tick();
    tick();
    jtag_req = 1; wb_req = 1;
    nr = 0; nf = 0;
    for (int c = 0; c < 60 && (nr < 3 || nf < 3); c++) begin
      tick();
      if (nr < 3 && (if_rr.jtag_ack || if_rr.wb_ack)) begin rr_ord[nr] = {if_rr.wb_ack, if_rr.jtag_ack}; nr++; end
      if (nf < 3 && (if_fp.jtag_ack || if_fp.wb_ack)) begin fp_ord[nf] = {if_fp.wb_ack, if_fp.jtag_ack}; nf++; end
    end
    checks++; if (nr != 3 || nf != 3) begin errors++; $display("FAIL cont_b_budget: got rr=%0d fp=%0d grants want 3", nr, nf); end
    for (int i = 0; i < 3; i++) begin
      if (i < nr) begin checks++; if (rr_ord[i] !== exp_rr_b[i]) begin errors++; $display("FAIL cont_b_rr[%0d]: got %b want %b", i, rr_ord[i], exp_rr_b[i]); end end
      if (i < nf) begin checks++; if (fp_ord[i] !== exp_fp_b[i]) begin errors++; $display("FAIL cont_b_fp[%0d]: got %b want %b", i, fp_ord[i], exp_fp_b[i]); end end
    end
    idle_inputs();
  endtask

  task automatic test_timeout();
    int cnt;
    bit seen;
    do_reset();
    jtag_req = 1; jtag_we = 0; jtag_be = 4'hF; jtag_addr = 20'h00020;
    mgmt_ready = 0; mgmt_rdata = 32'h0000_0077;
    tick();
    cnt = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (if_rr.jtag_ack) begin seen = 1; break; end
      if (if_rr.management_enable) cnt++;
      tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL to_ack: got no jtag_ack want ack"); end
    checks++; if (cnt != 4) begin errors++; $display("FAIL to_cycles: got %0d want 4", cnt); end
    checks++; if (if_rr.jtag_error !== 1'b1) begin errors++; $display("FAIL to_error: got %b want 1", if_rr.jtag_error); end
    checks++; if (if_rr.jtag_readData !== 32'hFFFFFFFF) begin errors++; $display("FAIL to_rdata: got %h want ffffffff", if_rr.jtag_readData); end
    jtag_req = 0;
    tick();
    tick();
    jtag_req = 1; mgmt_ready = 1; mgmt_rdata = 32'h0BADF00D;
    tick();
    tick();
    checks++; if (if_rr.jtag_ack !== 1'b1) begin errors++; $display("FAIL to_next_ack: got %b want 1", if_rr.jtag_ack); end
    checks++; if (if_rr.jtag_error !== 1'b0) begin errors++; $display("FAIL to_next_error: got %b want 0", if_rr.jtag_error); end
    checks++; if (if_rr.jtag_readData !== 32'h0BADF00D) begin errors++; $display("FAIL to_next_rdata: got %h want 0badf00d", if_rr.jtag_readData); end
    jtag_req = 0;
    tick();
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    do_reset();
    wb_req = 1; wb_we = 0; wb_be = 4'hF; wb_addr = 20'h00100;
    mgmt_ready = 0; mgmt_rdata = 32'h5A5A0001;
    tick();
    checks++; if ({if_rr.management_enable, if_rr.active_requester} !== {1'b1, REQ_WB}) begin errors++; $display("FAIL rm_access: got %b want 110", {if_rr.management_enable, if_rr.active_requester}); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if (if_rr.management_enable !== 1'b0) begin errors++; $display("FAIL rm_enable: got %b want 0", if_rr.management_enable); end
    checks++; if ({if_rr.wb_ack, if_rr.active_requester, if_rr.management_address} !== 23'd0) begin errors++; $display("FAIL rm_outputs: got %h want 0", {if_rr.wb_ack, if_rr.active_requester, if_rr.management_address}); end
    checks++; if (if_rr.arb_state !== ARB_IDLE) begin errors++; $display("FAIL rm_state: got %0d want 0", if_rr.arb_state); end
    mgmt_ready = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (if_rr.wb_ack) seen = 1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rm_retry_ack: got no wb_ack want ack"); end
    checks++; if (if_rr.wb_readData !== 32'h5A5A0001) begin errors++; $display("FAIL rm_retry_rdata: got %h want 5a5a0001", if_rr.wb_readData); end
    wb_req = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    jtag_req = 1; jtag_we = 0; jtag_be = 4'hF; jtag_addr = 20'h00030;
    mgmt_ready = 1; mgmt_rdata = 32'h11111111;
    tick();
    tick();
    checks++; if (if_rr.jtag_ack !== 1'b1) begin errors++; $display("FAIL bb_first_ack: got %b want 1", if_rr.jtag_ack); end
    tick();
    checks++; if (if_rr.management_enable !== 1'b0) begin errors++; $display("FAIL bb_idle: got %b want 0", if_rr.management_enable); end
    mgmt_rdata = 32'h22222222;
    tick();
    checks++; if (if_rr.management_enable !== 1'b0) begin errors++; $display("FAIL bb_masked: got %b want 0", if_rr.management_enable); end
    tick();
    checks++; if (if_rr.management_enable !== 1'b1) begin errors++; $display("FAIL bb_restart: got %b want 1", if_rr.management_enable); end
    tick();
    checks++; if (if_rr.jtag_ack !== 1'b1) begin errors++; $display("FAIL bb_second_ack: got %b want 1", if_rr.jtag_ack); end
    checks++; if (if_rr.jtag_readData !== 32'h22222222) begin errors++; $display("FAIL bb_second_rdata: got %h want 22222222", if_rr.jtag_readData); end
    jtag_req = 0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_jtag_read();
    test_wb_write();
    test_contention();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/management_bus_arbiter.md
Name: management_bus_arbiter

Overview:
- Shares the core's single management port between two requesters: the JTAG debug controller and the Wishbone/host-side management bridge.
- Serialises their accesses, captures read data and returns a one-cycle acknowledge to the winning requester.
- Adds round-robin fairness and a bounded wait on the target via a timeout with an error flag.
- Sits between the requesters and the core's management_* port.

Parameters:
ROUND_ROBIN, 1, 1 = alternate grants on contention; 0 = fixed priority with JTAG winning.
TIMEOUT_CYCLES, 255, max cycles in ACCESS waiting for management_ready; 0 disables the timeout.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
jtag_req  input  1  level request, held until jtag_ack
jtag_writeEnable  input  1  1 = write, 0 = read
jtag_byteSelect  input  4  byte lanes
jtag_address  input  20  word address
jtag_writeData  input  32  write data
jtag_ack  output  1  one-cycle completion pulse
jtag_error  output  1  valid with jtag_ack; timeout occurred
jtag_readData  output  32  read result, held until next jtag_ack
wb_req, wb_writeEnable, wb_byteSelect, wb_address, wb_writeData, wb_ack, wb_error, wb_readData  same as jtag_*
management_enable  output  1  target access strobe
management_writeEnable  output  1  target write
management_byteSelect  output  4  target byte lanes
management_address  output  20  target address
management_writeData  output  32  target write data
management_readData  input  32  target read data
management_ready  input  1  target completes in the current cycle
active_requester  output  2  00 none, 01 JTAG, 10 WB (probe)

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset: state IDLE; all outputs 0; readData registers 0; lastGrant = WB, so JTAG wins the first tie; timeout counter 0.
- IDLE:
  - Sample requests, excluding any requester acked in the previous cycle (one-cycle mask).
  - Winner when both request: if ROUND_ROBIN, the requester not equal to lastGrant; else JTAG.
  - Latch the winner's writeEnable, byteSelect, address and writeData into internal registers; clear the counter; go to ACCESS.
  - Latency: req seen at cycle N gives management_enable high at N+1.
- ACCESS:
  - management_enable = 1; management_writeEnable, byteSelect and address come from the latched values.
  - management_writeData = latched data if write, else 0.
  - active_requester is the granted ID; requester inputs are ignored (no mid-access change).
  - If management_ready: capture management_readData for reads (0 for writes), error = 0, go to DONE.
  - Else if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: error = 1, readData = 32'hFFFFFFFF, go to DONE.
  - Else increment the counter.
  - A ready in the first ACCESS cycle gives a 1-cycle access.
- DONE:
  - Pulse the granted requester's ack for exactly one cycle; update that requester's readData/error registers.
  - lastGrant = granted ID; management_enable = 0; go to IDLE.
  - The other requester's readData/error are unchanged.
- Request dropped before ack: the access still completes and ack is still pulsed.
- Write with byteSelect 0: passed through unchanged; the arbiter does not filter it.
- Reset mid-ACCESS: abort immediately; no ack is issued; the target strobe drops in the next cycle.
- Counter width: $clog2(TIMEOUT_CYCLES+1); it never wraps.

Decomposition:
- Shared package holds:
  - state encodings: ARB_IDLE = 2'd0, ARB_ACCESS = 2'd1, ARB_DONE = 2'd2;
  - requester IDs: REQ_NONE = 2'b00, REQ_JTAG = 2'b01, REQ_WB = 2'b10;
  - TIMEOUT_READ_VALUE = 32'hFFFFFFFF.
- One natural sub-module: round_robin_arbiter2. It takes the two masked requests, lastGrant and ROUND_ROBIN, and produces a combinational one-hot grant.
- The rest stays in this module.

Test Plan:
- JTAG read only, addr 20'h00010, target ready on its 1st ACCESS cycle returning 32'hDEADBEEF -> enable high for 1 cycle at N+1, jtag_ack at N+2, jtag_readData = 32'hDEADBEEF, jtag_error = 0, wb_ack never asserts.
- WB write addr 20'h00404, data 32'h12345678, byteSelect 4'h3, ready after 3 cycles -> management_writeData = 32'h12345678 and byteSelect 3 for 3 cycles, wb_ack one cycle later.
- Both requesting continuously after reset, ROUND_ROBIN = 1 -> grant order JTAG, WB, JTAG, WB. With ROUND_ROBIN = 0 -> JTAG is granted whenever jtag_req is high at IDLE.
- TIMEOUT_CYCLES = 4, management_ready stuck 0 on a JTAG read -> 4 ACCESS cycles, jtag_ack with jtag_error = 1 and jtag_readData = 32'hFFFFFFFF; the next access with ready = 1 clears the error.
- rst pulsed during a WB ACCESS cycle -> next cycle all outputs 0, no wb_ack; a subsequent WB request completes normally.
- Requester holds req one cycle past ack -> the second access is not started (mask); req still high on the following cycle -> a new access starts.
